// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes and data-memory freeze with
// a wait timeout. Outputs are Mealy on the registered state and current inputs.
module hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_MEM_WAIT = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_hold,
  output logic             mem_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned WcW = $clog2(MAX_MEM_WAIT + 1);
  localparam logic [FcW-1:0] FlushReload = FcW'(FLUSH_CYCLES - 1);
  localparam logic [WcW-1:0] WaitMax     = WcW'(MAX_MEM_WAIT);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StFlush   = 2'b01,
    StMemWait = 2'b10,
    StTimeout = 2'b11
  } state_e;

  state_e           state_q, state_d, ret_q, ret_d, eff;
  logic [FcW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [WcW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_count_q;
  logic             pc_w, ifw, flush, bubble, hold, tmo;
  logic             load_use;

  assign load_use = id_valid & ex_mem_read & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    pc_w        = 1'b1;
    ifw         = 1'b1;
    flush       = 1'b0;
    bubble      = 1'b0;
    hold        = 1'b0;
    tmo         = 1'b0;
    eff         = state_q;
    // The cycle memory releases is already live and behaves as the interrupted state.
    if (state_q == StMemWait && !mem_busy) begin
      eff        = ret_q;
      state_d    = ret_q;
      wait_cnt_d = '0;
    end
    case (eff)
      StRun, StFlush: begin
        if (mem_busy) begin
          pc_w       = 1'b0;
          ifw        = 1'b0;
          hold       = 1'b1;
          ret_d      = eff;
          wait_cnt_d = WcW'(1);
          state_d    = (MAX_MEM_WAIT == 1) ? StTimeout : StMemWait;
        end else if (ex_redirect) begin
          flush  = 1'b1;
          bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = StFlush;
            flush_cnt_d = FlushReload;
          end else begin
            state_d = StRun;
          end
        end else if (eff == StFlush) begin
          flush       = 1'b1;
          bubble      = 1'b1;
          flush_cnt_d = flush_cnt_q - FcW'(1);
          state_d     = (flush_cnt_q == FcW'(1)) ? StRun : StFlush;
        end else if (load_use) begin
          pc_w    = 1'b0;
          ifw     = 1'b0;
          bubble  = 1'b1;
          state_d = StRun;
        end else begin
          state_d = StRun;
        end
      end
      StMemWait: begin
        pc_w       = 1'b0;
        ifw        = 1'b0;
        hold       = 1'b1;
        wait_cnt_d = wait_cnt_q + WcW'(1);
        if (wait_cnt_d == WaitMax) state_d = StTimeout;
      end
      StTimeout: begin
        pc_w = 1'b0;
        ifw  = 1'b0;
        hold = 1'b1;
        tmo  = 1'b1;
      end
      default: ;
    endcase
  end

  // Force reset values onto the outputs while reset is held, regardless of inputs.
  assign pc_write     = pc_w | ~reset;
  assign if_id_write  = ifw | ~reset;
  assign if_id_flush  = flush & reset;
  assign id_ex_bubble = bubble & reset;
  assign id_ex_hold   = hold & reset;
  assign mem_timeout  = tmo & reset;
  assign state        = state_q;
  assign stall_count  = stall_count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StRun;
      ret_q         <= StRun;
      flush_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      stall_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      if (!pc_write && stall_count_q != {CNT_W{1'b1}}) begin
        stall_count_q <= stall_count_q + CNT_W'(1);
      end
    end
  end

endmodule
